// File: rtl/sipo_register_param.sv
// sipo_register_param: serial-in / parallel-out receiver with a one-deep
// output holding register, consumer handshake and sticky error flags.
//
// Build option: define SIPO_PARITY_EN to append one parity bit after every
// data word (sense selected by PARITY_ODD). Without it the parity flag is
// tied low and no parity state exists.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for read; counter and shift register are zero
// SHIFT  | consuming data bits, one per clock with shift_en=1
// PARITY | (SIPO_PARITY_EN only) waiting for the trailing parity bit
module sipo_register_param #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_in,
    input  logic             shift_en,
    input  logic             read,
    input  logic             clear,
    input  logic             ack,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
`ifdef SIPO_PARITY_EN
    localparam logic [CW-1:0] ALL_DATA = CW'(WIDTH);
`endif

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;

    // Shift register contents after taking data_in in the selected bit order.
    // LSB-first shifts toward bit 0 so the first bit ends up in out[0].
    always_comb begin
        sr_next = sr;
        if (MSB_FIRST)
            sr_next = {sr[WIDTH-2:0], data_in};
        else
            sr_next = {data_in, sr[WIDTH-1:1]};
    end

    assign busy = (state != ST_IDLE);

    // Receive FSM, bit counter, output register and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sr        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (clear) begin
            // clear wins over everything; the delivered word stays visible
            state   <= ST_IDLE;
            cnt     <= '0;
            sr      <= '0;
            overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // A completion later in this block overrides this release,
            // which is how ack-with-completion keeps out_valid high.
            if (ack && out_valid)
                out_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (read) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        sr    <= '0;
                    end
                end

                ST_SHIFT: begin
                    if (!read) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        sr    <= '0;
                    end else if (shift_en) begin
                        sr <= sr_next;
                        if (cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                            state <= ST_PARITY;
                            cnt   <= ALL_DATA;
`else
                            state     <= ST_IDLE;
                            cnt       <= '0;
                            sr        <= '0;
                            out       <= sr_next;
                            out_valid <= 1'b1;
                            if (out_valid && !ack)
                                overrun <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

`ifdef SIPO_PARITY_EN
                ST_PARITY: begin
                    if (!read) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        sr    <= '0;
                    end else if (shift_en) begin
                        // data_in is the parity bit; the word is delivered
                        // whether or not it checks out
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        sr        <= '0;
                        out       <= sr;
                        out_valid <= 1'b1;
                        if (out_valid && !ack)
                            overrun <= 1'b1;
                        if ((^sr ^ data_in) != PARITY_ODD)
                            parity_err <= 1'b1;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    sr    <= '0;
                end
            endcase
        end
    end

`ifndef SIPO_PARITY_EN
    // No parity bit is received in this build, so the flag is constant low;
    // the parity sense is folded in only so the parameter stays referenced.
    assign parity_err = PARITY_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_sipo_register_param.sv
// Directed bench for sipo_register_param: two instances (LSB-first and
// MSB-first) share the same stimulus. Builds with or without SIPO_PARITY_EN.
module tb_sipo_register_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       data_in;
    logic       shift_en;
    logic       read;
    logic       clear;
    logic       ack;

    logic [7:0] out_a, out_b;
    logic       valid_a, busy_a, ovr_a, perr_a;
    logic       valid_b, busy_b, ovr_b, perr_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sipo_register_param #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .shift_en(shift_en),
        .read(read), .clear(clear), .ack(ack), .out(out_a), .out_valid(valid_a),
        .busy(busy_a), .overrun(ovr_a), .parity_err(perr_a)
    );

    sipo_register_param #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .shift_en(shift_en),
        .read(read), .clear(clear), .ack(ack), .out(out_b), .out_valid(valid_b),
        .busy(busy_b), .overrun(ovr_b), .parity_err(perr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bits[i] is the i-th bit on the wire
    task automatic shift_bits(input logic [31:0] bits, input int n,
                              input logic ack_last, input bit gap);
        for (int i = 0; i < n; i++) begin
            data_in  = bits[i];
            shift_en = 1'b1;
            ack      = ack_last && (i == n - 1);
            tick();
            shift_en = 1'b0;
            ack      = 1'b0;
            if (gap && i != n - 1)
                tick();
        end
    endtask

    // Full word; in the parity build a correct even-parity bit follows
    task automatic send_word(input logic [7:0] w, input logic ack_last, input bit gap);
`ifdef SIPO_PARITY_EN
        shift_bits({24'b0, w}, 8, 1'b0, gap);
        shift_bits({31'b0, ^w}, 1, ack_last, 1'b0);
`else
        shift_bits({24'b0, w}, 8, ack_last, gap);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        data_in  = 1'b0;
        shift_en = 1'b0;
        read     = 1'b0;
        clear    = 1'b0;
        ack      = 1'b0;
        #2;
        chk("rst_out",   32'(out_a),   32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_busy",  32'(busy_a),  32'h0);
        chk("rst_ovr",   32'(ovr_a),   32'h0);
        chk("rst_perr",  32'(perr_a),  32'h0);
        chk("rst_perr_b", 32'(perr_b), 32'h0);

        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        // first word, LSB-first 0x4D / MSB-first 0xB2
        read = 1'b1;
        tick();
        chk("enter_busy", 32'(busy_a), 32'h1);
        send_word(8'h4D, 1'b0, 1'b0);
        chk("w1_out_lsb",   32'(out_a),   32'h4D);
        chk("w1_out_msb",   32'(out_b),   32'hB2);
        chk("w1_valid",     32'(valid_a), 32'h1);
        chk("w1_valid_b",   32'(valid_b), 32'h1);
        chk("w1_busy_done", 32'(busy_a),  32'h0);
        chk("w1_perr",      32'(perr_a),  32'h0);
        tick();
        chk("b2b_reenter",  32'(busy_a),  32'h1);

        // second word without ack, with shift_en gaps -> overrun
        send_word(8'h12, 1'b0, 1'b1);
        chk("w2_out_lsb", 32'(out_a), 32'h12);
        chk("w2_out_msb", 32'(out_b), 32'h48);
        chk("w2_valid",   32'(valid_a), 32'h1);
        chk("w2_ovr",     32'(ovr_a), 32'h1);
        chk("w2_ovr_b",   32'(ovr_b), 32'h1);

        // clear beats ack and read
        clear = 1'b1;
        ack   = 1'b1;
        tick();
        clear = 1'b0;
        ack   = 1'b0;
        chk("clr_ovr",   32'(ovr_a),   32'h0);
        chk("clr_valid", 32'(valid_a), 32'h1);
        chk("clr_busy",  32'(busy_a),  32'h0);
        chk("clr_out",   32'(out_a),   32'h12);

        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_clears", 32'(valid_a), 32'h0);
        chk("ack_hold_busy", 32'(busy_b), 32'h1);

        // ack on completion cycle of the second word keeps overrun low
        send_word(8'h4D, 1'b0, 1'b0);
        chk("w3_valid", 32'(valid_a), 32'h1);
        tick();
        send_word(8'h12, 1'b1, 1'b0);
        chk("ackc_out",   32'(out_a),   32'h12);
        chk("ackc_valid", 32'(valid_a), 32'h1);
        chk("ackc_ovr",   32'(ovr_a),   32'h0);

        // partial word aborted by read=0, shift_en ignored while idle
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        shift_bits(32'h0, 3, 1'b0, 1'b0);
        read = 1'b0;
        tick();
        chk("abort_busy",  32'(busy_a),  32'h0);
        chk("abort_out",   32'(out_a),   32'h12);
        chk("abort_valid", 32'(valid_a), 32'h0);
        shift_bits(32'hFF, 8, 1'b0, 1'b0);
        chk("idle_ign_valid", 32'(valid_a), 32'h0);
        chk("idle_ign_busy",  32'(busy_a),  32'h0);
        read = 1'b1;
        tick();
        shift_bits(32'hFF, 5, 1'b0, 1'b0);
        chk("no_early_done", 32'(valid_a), 32'h0);
        shift_bits(32'h7, 3, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
        shift_bits(32'h0, 1, 1'b0, 1'b0);
`endif
        chk("ff_out_lsb", 32'(out_a),   32'hFF);
        chk("ff_out_msb", 32'(out_b),   32'hFF);
        chk("ff_valid",   32'(valid_a), 32'h1);

        // build up overrun, then reset mid-word asynchronously
        tick();
        send_word(8'h4D, 1'b0, 1'b0);
        chk("pre_rst_ovr", 32'(ovr_a), 32'h1);
        tick();
        shift_bits(32'h5, 3, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out",   32'(out_a),   32'h0);
        chk("arst_out_b", 32'(out_b),   32'h0);
        chk("arst_valid", 32'(valid_a), 32'h0);
        chk("arst_busy",  32'(busy_a),  32'h0);
        chk("arst_ovr",   32'(ovr_a),   32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

`ifdef SIPO_PARITY_EN
        // even parity: 0x4D with parity bit 1 is wrong
        shift_bits(32'h4D, 8, 1'b0, 1'b0);
        shift_bits(32'h1, 1, 1'b0, 1'b0);
        chk("par_err",   32'(perr_a),  32'h1);
        chk("par_out",   32'(out_a),   32'h4D);
        chk("par_valid", 32'(valid_a), 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("par_clr",       32'(perr_a),  32'h0);
        chk("par_clr_valid", 32'(valid_a), 32'h1);
`else
        send_word(8'h4D, 1'b0, 1'b0);
        chk("nopar_out",  32'(out_a),  32'h4D);
        chk("nopar_perr", 32'(perr_a), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
